generic_stream_fifo: RTL and testbench
======================================

Name: generic_stream_fifo

Overview:
Parametrised valid/ready stream FIFO that carries a generic payload of configurable width between producer and consumer sides of a stream interface. It is the successor to the fixed-width generic interface instances. It adds selectable depth, an almost-full threshold, a synchronous flush, and an optional first-word-fall-through mode. It sits on any stream boundary that needs elastic buffering, for example between a generic interface instance and a downstream module.

Parameters:
WIDTH, 2, payload width in bits (>=1); matches a 2-bit packed struct payload by default
DEPTH, 4, number of storage entries (>=1, need not be a power of two)
AF_THRESHOLD, DEPTH-1, o_almost_full asserts when count >= AF_THRESHOLD (1..DEPTH)
FWFT, 1, 1 = first-word-fall-through (head valid on o_pop_data); 0 = registered read (data one cycle after pop)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_clear  input  1  synchronous flush; empties FIFO, keeps configuration
i_push_valid  input  1  producer has data
o_push_ready  output  1  FIFO accepts data (= !full)
i_push_data  input  WIDTH  producer payload
o_pop_valid  output  1  consumer data available
i_pop_ready  input  1  consumer accepts data
o_pop_data  output  WIDTH  consumer payload
o_count  output  $clog2(DEPTH+1)  current occupancy
o_empty  output  1  count == 0
o_full  output  1  count == DEPTH
o_almost_full  output  1  count >= AF_THRESHOLD

Behaviour:
- Reset (i_rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs after reset: o_pop_valid=0, o_push_ready=1, o_empty=1, o_full=0, o_almost_full=0 (unless AF_THRESHOLD=0, which is illegal), o_count=0, o_pop_data=0.
- Push fires when i_push_valid && o_push_ready. Pop fires when o_pop_valid && i_pop_ready.
- o_push_ready depends only on state (!full); there is no combinational path from i_pop_ready. Consequence: a push on a full FIFO is refused even if a pop fires in the same cycle.
- Pointer wrap: a pointer equal to DEPTH-1 returns to 0 on increment. No power-of-two assumption.
- count update on the next edge: +1 on push only, -1 on pop only, unchanged on both or neither. count never exceeds DEPTH and never underflows.
- FWFT=1:
  - o_pop_valid = !empty.
  - o_pop_data = mem[rd_ptr] (combinational from storage).
  - Push-to-pop latency is 1 cycle: data pushed at edge t is visible at o_pop_valid after edge t.
  - Pop while empty is impossible; simultaneous push and pop when empty: only the push fires.
- FWFT=0:
  - Output register stage: o_pop_valid/o_pop_data are registered.
  - The output register is refilled from storage whenever it is empty, or when it is popped and storage is non-empty.
  - Push-to-pop latency is 2 cycles. o_count includes the output register entry, so total capacity stays DEPTH.
- o_pop_data holds its last value while o_pop_valid=0. Do not check it as X.
- Data ordering is strictly FIFO. No data is lost or duplicated under any valid/ready pattern, including back-to-back push+pop at count=DEPTH-1, DEPTH and 1.
- Stability:
  - Once o_pop_valid=1, o_pop_data is stable until the pop fires.
  - Once o_push_ready=0, it stays 0 until a pop fires, i_clear or i_rst.
- i_clear has the same effect as reset on pointers, count and the output register, but does not clear storage contents.
  - A push or pop in the same cycle as i_clear is discarded.
  - i_rst has priority over i_clear.
- Reset or clear mid-burst: the FIFO is empty on the next cycle. The first push afterwards lands at entry 0.
- Flags o_empty, o_full and o_almost_full are decoded from registered count, so they are glitch-free and updated the cycle after the event.

Test Plan:
- Reset then idle: hold i_rst 2 cycles -> o_empty=1, o_push_ready=1, o_pop_valid=0, o_count=0.
- Fill to full (DEPTH=4, FWFT=1): push 0,1,2,3 with i_pop_ready=0 -> o_count=4, o_full=1, o_push_ready=0, o_almost_full=1 from count 3. A fifth push is refused. Then pop all -> data 0,1,2,3 in order, o_empty=1.
- Simultaneous push+pop at full: count=4, i_push_valid=1, i_pop_ready=1 -> only the pop fires, count=3. Next cycle push accepted, count stays 3 with continuous push+pop. Stream 0..99 through, output matches input.
- Wrap-around with DEPTH=3: random valid/ready at 50% for 1000 transfers -> scoreboard order exact, count always in 0..3, pointers wrap after entry 2.
- Flush mid-burst: count=3, assert i_clear with i_push_valid=1 -> next cycle count=0, o_pop_valid=0, pushed word discarded. Next push 0xA (WIDTH=4) -> first popped word is 0xA.
- FWFT=0 latency: push 0x2 at edge t into an empty FIFO -> o_pop_valid=1 after edge t+1 with o_pop_data=0x2, o_count=1 after edge t.

Source files
------------

// File: rtl/generic_stream_fifo.sv
// Parametrised valid/ready stream FIFO with selectable depth, almost-full
// threshold, synchronous flush and optional first-word-fall-through output.
module generic_stream_fifo #(
    parameter int WIDTH        = 2,
    parameter int DEPTH        = 4,
    parameter int AF_THRESHOLD = DEPTH - 1,
    parameter int FWFT         = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push_valid,
    output logic                       o_push_ready,
    input  logic [WIDTH-1:0]           i_push_data,
    output logic                       o_pop_valid,
    input  logic                       i_pop_ready,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_almost_full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESHOLD);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    store_cnt;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push_fire, pop_fire, mem_we;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign o_push_ready  = (count_q != DEPTH_C);
    assign o_pop_valid   = (FWFT != 0) ? (count_q != '0) : out_valid_q;
    // out_data_q doubles as the hold register for FWFT once the FIFO drains
    assign o_pop_data    = ((FWFT != 0) && (count_q != '0)) ? mem_q[rd_ptr_q] : out_data_q;
    assign o_count       = count_q;
    assign o_empty       = (count_q == '0);
    assign o_full        = (count_q == DEPTH_C);
    assign o_almost_full = (count_q >= AF_C);

    always_comb begin
        push_fire   = i_push_valid && o_push_ready;
        pop_fire    = o_pop_valid && i_pop_ready;
        mem_we      = push_fire && !i_clear;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        store_cnt   = count_q - CW'(out_valid_q);

        if (push_fire) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (FWFT != 0) begin
            if (pop_fire) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                out_data_d = mem_q[rd_ptr_q];
            end
        end else if (!out_valid_q || pop_fire) begin
            // Output register refills from storage only; a same-cycle push is not bypassed
            if (store_cnt != '0) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_q[rd_ptr_q];
                rd_ptr_d    = ptr_inc(rd_ptr_q);
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (push_fire && !pop_fire) begin
            count_d = count_q + 1'b1;
        end else if (!push_fire && pop_fire) begin
            count_d = count_q - 1'b1;
        end

        if (i_clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_generic_stream_fifo.sv
// Scoreboard bench for generic_stream_fifo: one FWFT instance (depth 4) and one
// registered-read instance (depth 3), checked against queue-based models.
module tb_generic_stream_fifo;
    localparam int W  = 4;
    localparam int DA = 4;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_clear = 1'b0, a_push_valid = 1'b0, a_pop_ready = 1'b0;
    logic [W-1:0] a_push_data = '0;
    logic         a_push_ready, a_pop_valid, a_empty, a_full, a_af;
    logic [W-1:0] a_pop_data;
    logic [2:0]   a_count;

    logic         b_clear = 1'b0, b_push_valid = 1'b0, b_pop_ready = 1'b0;
    logic [W-1:0] b_push_data = '0;
    logic         b_push_ready, b_pop_valid, b_empty, b_full, b_af;
    logic [W-1:0] b_pop_data;
    logic [1:0]   b_count;

    generic_stream_fifo #(.WIDTH(W), .DEPTH(DA), .AF_THRESHOLD(3), .FWFT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_clear(a_clear),
        .i_push_valid(a_push_valid), .o_push_ready(a_push_ready), .i_push_data(a_push_data),
        .o_pop_valid(a_pop_valid), .i_pop_ready(a_pop_ready), .o_pop_data(a_pop_data),
        .o_count(a_count), .o_empty(a_empty), .o_full(a_full), .o_almost_full(a_af)
    );

    generic_stream_fifo #(.WIDTH(W), .DEPTH(DB), .AF_THRESHOLD(2), .FWFT(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_clear(b_clear),
        .i_push_valid(b_push_valid), .o_push_ready(b_push_ready), .i_push_data(b_push_data),
        .o_pop_valid(b_pop_valid), .i_pop_ready(b_pop_ready), .o_pop_data(b_pop_data),
        .o_count(b_count), .o_empty(b_empty), .o_full(b_full), .o_almost_full(b_af)
    );

    int           total = 0;
    int           bad = 0;
    int           b_xfers = 0;
    logic         mon_en = 1'b0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs are set at negedge+1; record accepted pushes, then advance one cycle.
    task automatic tick();
        if (!rst && !a_clear && a_push_valid && a_push_ready) qa.push_back(a_push_data);
        if (!rst && !b_clear && b_push_valid && b_push_ready) qb.push_back(b_push_data);
        if (!rst && !b_clear && b_pop_valid && b_pop_ready) b_xfers++;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_push_valid = 1'b0; a_pop_ready = 1'b0; a_clear = 1'b0;
        b_push_valid = 1'b0; b_pop_ready = 1'b0; b_clear = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        a_pop_ready = 1'b1;
        b_pop_ready = 1'b1;
        for (int n = 0; n < 40 && (qa.size() != 0 || qb.size() != 0); n++) tick();
        chk("drain_a_left", 32'(qa.size()), 32'd0);
        chk("drain_b_left", 32'(qb.size()), 32'd0);
        chk("drain_a_empty", 32'(a_empty), 32'd1);
        chk("drain_b_empty", 32'(b_empty), 32'd1);
        idle_inputs();
    endtask

    // Monitor: state checks at negedge, pop handshake checks at negedge+3.
    logic         a_hold = 1'b0, b_hold = 1'b0;
    logic [W-1:0] a_held = '0, b_held = '0;
    logic [W-1:0] exp_d;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("a_count", 32'(a_count), 32'(qa.size()));
                chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
                chk("a_full", 32'(a_full), 32'(qa.size() == DA));
                chk("a_almost_full", 32'(a_af), 32'(qa.size() >= 3));
                chk("a_push_ready", 32'(a_push_ready), 32'(qa.size() != DA));
                chk("a_pop_valid", 32'(a_pop_valid), 32'(qa.size() != 0));
                chk("b_count", 32'(b_count), 32'(qb.size()));
                chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
                chk("b_full", 32'(b_full), 32'(qb.size() == DB));
                chk("b_almost_full", 32'(b_af), 32'(qb.size() >= 2));
                chk("b_push_ready", 32'(b_push_ready), 32'(qb.size() != DB));
                chk("b_valid_without_data", 32'(b_pop_valid && qb.size() == 0), 32'd0);
            end
            #3;
            if (rst || a_clear) begin
                qa.delete();
                a_hold = 1'b0;
            end else begin
                if (a_hold) begin
                    chk("a_hold_valid", 32'(a_pop_valid), 32'd1);
                    chk("a_hold_data", 32'(a_pop_data), 32'(a_held));
                end
                if (a_pop_valid && a_pop_ready) begin
                    if (qa.size() == 0) begin
                        total++; bad++;
                        $display("FAIL a_pop_underflow: got=%0h want=none at %0t", a_pop_data, $time);
                    end else begin
                        exp_d = qa.pop_front();
                        chk("a_pop_data", 32'(a_pop_data), 32'(exp_d));
                    end
                end
                a_hold = a_pop_valid && !a_pop_ready;
                a_held = a_pop_data;
            end
            if (rst || b_clear) begin
                qb.delete();
                b_hold = 1'b0;
            end else begin
                if (b_hold) begin
                    chk("b_hold_valid", 32'(b_pop_valid), 32'd1);
                    chk("b_hold_data", 32'(b_pop_data), 32'(b_held));
                end
                if (b_pop_valid && b_pop_ready) begin
                    if (qb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL b_pop_underflow: got=%0h want=none at %0t", b_pop_data, $time);
                    end else begin
                        exp_d = qb.pop_front();
                        chk("b_pop_data", 32'(b_pop_data), 32'(exp_d));
                    end
                end
                b_hold = b_pop_valid && !b_pop_ready;
                b_held = b_pop_data;
            end
        end
    end

    initial begin
        int cyc;
        // Reset held for two edges
        @(negedge clk);
        #1;
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_a_count", 32'(a_count), 32'd0);
        chk("rst_a_empty", 32'(a_empty), 32'd1);
        chk("rst_a_push_ready", 32'(a_push_ready), 32'd1);
        chk("rst_a_pop_valid", 32'(a_pop_valid), 32'd0);
        chk("rst_a_pop_data", 32'(a_pop_data), 32'd0);
        chk("rst_b_pop_valid", 32'(b_pop_valid), 32'd0);
        chk("rst_b_pop_data", 32'(b_pop_data), 32'd0);
        chk("rst_b_af", 32'(b_af), 32'd0);

        // Registered-read latency: count after one edge, data after two
        b_push_valid = 1'b1; b_push_data = 4'h2;
        tick();
        b_push_valid = 1'b0;
        chk("b_lat_count", 32'(b_count), 32'd1);
        chk("b_lat_valid_early", 32'(b_pop_valid), 32'd0);
        tick();
        chk("b_lat_valid", 32'(b_pop_valid), 32'd1);
        chk("b_lat_data", 32'(b_pop_data), 32'h2);
        b_pop_ready = 1'b1;
        tick();
        b_pop_ready = 1'b0;
        chk("b_lat_drained", 32'(b_count), 32'd0);

        // Fill FWFT instance to full
        for (int i = 0; i < DA; i++) begin
            a_push_valid = 1'b1; a_push_data = 4'(i);
            tick();
        end
        chk("fill_count", 32'(a_count), 32'd4);
        chk("fill_full", 32'(a_full), 32'd1);
        chk("fill_push_ready", 32'(a_push_ready), 32'd0);
        chk("fill_head", 32'(a_pop_data), 32'd0);
        a_push_data = 4'h9;
        tick();
        chk("fifth_refused", 32'(a_count), 32'd4);

        // Push+pop at full: only the pop fires
        a_push_data = 4'h5; a_pop_ready = 1'b1;
        tick();
        chk("full_pushpop_count", 32'(a_count), 32'd3);
        for (int i = 0; i < 100; i++) begin
            a_push_valid = 1'b1; a_push_data = 4'(i); a_pop_ready = 1'b1;
            tick();
        end
        chk("stream_count", 32'(a_count), 32'd3);
        drain();

        // Flush mid-burst discards the concurrent push
        for (int i = 0; i < 3; i++) begin
            a_push_valid = 1'b1; a_push_data = 4'(i + 3);
            tick();
        end
        a_clear = 1'b1; a_push_data = 4'hF;
        tick();
        a_clear = 1'b0; a_push_valid = 1'b0;
        chk("flush_count", 32'(a_count), 32'd0);
        chk("flush_valid", 32'(a_pop_valid), 32'd0);
        a_push_valid = 1'b1; a_push_data = 4'hA;
        tick();
        a_push_valid = 1'b0;
        chk("flush_first_valid", 32'(a_pop_valid), 32'd1);
        chk("flush_first_data", 32'(a_pop_data), 32'hA);
        drain();

        // Random traffic on both instances
        b_xfers = 0;
        cyc = 0;
        while (b_xfers < 1000 && cyc < 20000) begin
            a_push_valid = 1'($urandom_range(0, 1));
            a_push_data  = 4'($urandom);
            a_pop_ready  = 1'($urandom_range(0, 1));
            a_clear      = ($urandom_range(0, 99) == 0);
            b_push_valid = 1'($urandom_range(0, 1));
            b_push_data  = 4'($urandom);
            b_pop_ready  = 1'($urandom_range(0, 1));
            b_clear      = ($urandom_range(0, 199) == 0);
            tick();
            cyc++;
        end
        chk("random_b_xfers_reached", 32'(b_xfers >= 1000), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
